// File: rtl/snn_pkg.sv
// snn_pkg: shared states, post-process op codes and burst/stage sizes for the SNN sequencer
package snn_pkg;
  typedef enum logic [3:0] {S_IDLE, S_LOAD, S_CONV, S_POOL, S_FC, S_NORM, S_ACT, S_DIST, S_OUT} state_t;
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_POOL = 3'd1;
  localparam logic [2:0] OP_FC = 3'd2;
  localparam logic [2:0] OP_NORM = 3'd3;
  localparam logic [2:0] OP_ACT = 3'd4;
  localparam logic [2:0] OP_DIST = 3'd5;
  localparam int N_IMG = 96;
  localparam int N_KER = 27;
  localparam int N_W = 4;
  localparam int N_IN = N_IMG + N_KER + N_W;
  localparam int N_CONV = 96;
  localparam int N_POOL = 8;
  localparam int N_FC = 8;
  localparam int N_NORM = 8;
  localparam int N_ACT = 8;
  localparam int N_DIST = 1;
  localparam int N_ISSUE = N_CONV + N_POOL + N_FC + N_NORM + N_ACT + N_DIST;
  localparam int CW = 10;
  function automatic logic [CW-1:0] stage_len(state_t s);
    return s == S_CONV ? CW'(N_CONV) : s == S_POOL ? CW'(N_POOL) : s == S_FC ? CW'(N_FC) :
           s == S_NORM ? CW'(N_NORM) : s == S_ACT ? CW'(N_ACT) : s == S_DIST ? CW'(N_DIST) : '0;
  endfunction
  function automatic logic [2:0] stage_op(state_t s);
    return s == S_POOL ? OP_POOL : s == S_FC ? OP_FC : s == S_NORM ? OP_NORM :
           s == S_ACT ? OP_ACT : s == S_DIST ? OP_DIST : OP_NONE;
  endfunction
endpackage

// File: rtl/snn_seq_ctrl_if.sv
// snn_seq_ctrl_if: input burst, buffer write, issue and result framing signals of the sequencer
interface snn_seq_ctrl_if;
  logic       in_valid;
  logic [1:0] Opt;
  logic       buf_we;
  logic [1:0] buf_sel;
  logic [6:0] buf_waddr;
  logic [1:0] opt_q;
  logic       cv_valid;
  logic       cv_img;
  logic [1:0] cv_row;
  logic [1:0] cv_col;
  logic [1:0] cv_ch;
  logic       cv_first;
  logic       cv_last;
  logic       pp_valid;
  logic [2:0] pp_op;
  logic [2:0] pp_idx;
  logic       out_valid;
  logic [1:0] out_idx;
  modport master (output in_valid, Opt,
                  input buf_we, buf_sel, buf_waddr, opt_q, cv_valid, cv_img, cv_row, cv_col, cv_ch,
                        cv_first, cv_last, pp_valid, pp_op, pp_idx, out_valid, out_idx);
  modport slave (input in_valid, Opt,
                 output buf_we, buf_sel, buf_waddr, opt_q, cv_valid, cv_img, cv_row, cv_col, cv_ch,
                        cv_first, cv_last, pp_valid, pp_op, pp_idx, out_valid, out_idx);
endinterface

// File: rtl/snn_stage_cnt.sv
// snn_stage_cnt: loadable down-counter; done marks the last cycle of the loaded window
module snn_stage_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == W'(1);
endmodule

// File: rtl/snn_seq_ctrl.sv
// snn_seq_ctrl: input burst counter and stage scheduler for the shared SNN FP datapath
module snn_seq_ctrl
  import snn_pkg::*;
#(
  parameter int DP_LAT  = 4,
  parameter int OUT_LEN = 1
) (
  input logic         clk,
  input logic         rst_n,
  snn_seq_ctrl_if.slave bus
);
  if (DP_LAT < 2 || OUT_LEN < 1 || OUT_LEN > 4 || N_ISSUE + 6 * DP_LAT > 1000) begin : g_bad_cfg
    $error("snn_seq_ctrl: unsupported DP_LAT/OUT_LEN");
  end
  state_t s, s_d, nxt;
  logic drn, drn_d, ld, done, full, stage, we;
  logic cv_d, pp_d, out_d;
  logic [CW-1:0] ld_val;
  logic [6:0] in_cnt, in_cnt_d, base;
  logic [2:0] seq, seq_d;
  logic [1:0] sel, ch_d;
  logic [4:0] pix, pix_d;
  snn_stage_cnt #(.W(CW)) u_cnt (.clk(clk), .rst_n(rst_n), .load(ld), .val(ld_val), .done(done));
  assign nxt = state_t'(s + 4'd1);
  assign full = in_cnt == 7'(N_IN);
  assign stage = s inside {[S_CONV:S_DIST]};
  assign we = rst_n && bus.in_valid && (s == S_IDLE || (s == S_LOAD && !full));
  assign sel = in_cnt < 7'(N_IMG) ? 2'd0 : in_cnt < 7'(N_IMG + N_KER) ? 2'd1 : 2'd2;
  assign base = sel == 2'd0 ? 7'd0 : sel == 2'd1 ? 7'(N_IMG) : 7'(N_IMG + N_KER);
  assign bus.buf_we = we;
  assign bus.buf_sel = we ? sel : 2'd0;
  assign bus.buf_waddr = we ? in_cnt - base : 7'd0;
  assign pix = {bus.cv_img, bus.cv_row, bus.cv_col};
  always_comb begin
    s_d = s;
    drn_d = drn;
    ld = 1'b0;
    ld_val = '0;
    if (s == S_IDLE) s_d = bus.in_valid ? S_LOAD : S_IDLE;
    else if (s == S_LOAD && !bus.in_valid) begin
      s_d = full ? S_CONV : S_IDLE;
      drn_d = 1'b0;
      ld = full;
      ld_val = stage_len(S_CONV);
    end else if (stage && done && !drn) begin
      // DIST's drain is one short so out_valid lands on the cycle its result appears
      drn_d = 1'b1;
      ld = 1'b1;
      ld_val = s == S_DIST ? CW'(DP_LAT - 1) : CW'(DP_LAT);
    end else if (stage && done) begin
      s_d = nxt;
      drn_d = 1'b0;
      ld = 1'b1;
      ld_val = nxt == S_OUT ? CW'(OUT_LEN) : stage_len(nxt);
    end else if (s == S_OUT && done) s_d = S_IDLE;
  end
  assign in_cnt_d = s == S_IDLE ? {6'd0, bus.in_valid} :
                    s == S_LOAD && bus.in_valid ? (full ? in_cnt : in_cnt + 7'd1) : 7'd0;
  assign seq_d = ld ? 3'd0 : seq + 3'd1;
  assign cv_d = s_d == S_CONV && !drn_d;
  assign pp_d = s_d inside {[S_POOL:S_DIST]} && !drn_d;
  assign out_d = s_d == S_OUT;
  assign ch_d = cv_d && bus.cv_valid ? (bus.cv_ch == 2'd2 ? 2'd0 : bus.cv_ch + 2'd1) : 2'd0;
  assign pix_d = cv_d && bus.cv_valid ? pix + 5'(bus.cv_ch == 2'd2) : 5'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= S_IDLE;
      drn <= 1'b0;
      in_cnt <= '0;
      seq <= '0;
      bus.opt_q <= '0;
      bus.cv_valid <= 1'b0;
      {bus.cv_img, bus.cv_row, bus.cv_col} <= '0;
      bus.cv_ch <= '0;
      bus.cv_first <= 1'b0;
      bus.cv_last <= 1'b0;
      bus.pp_valid <= 1'b0;
      bus.pp_op <= '0;
      bus.pp_idx <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx <= '0;
    end else begin
      s <= s_d;
      drn <= drn_d;
      in_cnt <= in_cnt_d;
      seq <= seq_d;
      if (s == S_IDLE && bus.in_valid) bus.opt_q <= bus.Opt;
      bus.cv_valid <= cv_d;
      {bus.cv_img, bus.cv_row, bus.cv_col} <= pix_d;
      bus.cv_ch <= ch_d;
      bus.cv_first <= cv_d && ch_d == 2'd0;
      bus.cv_last <= cv_d && ch_d == 2'd2;
      bus.pp_valid <= pp_d;
      bus.pp_op <= pp_d ? stage_op(s_d) : OP_NONE;
      bus.pp_idx <= pp_d ? seq_d : 3'd0;
      bus.out_valid <= out_d;
      bus.out_idx <= out_d ? seq_d[1:0] : 2'd0;
    end
endmodule

// File: tb/tb_snn_seq_ctrl.sv
// tb_snn_seq_ctrl: scoreboard bench for the SNN sequencer (writes, conv/pp streams, latency, reset)
module tb_snn_seq_ctrl;
  typedef struct {int t; logic [1:0] opt;} out_t;
  logic clk = 1'b0;
  logic rst_n;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int run = 0;
  out_t oe;
  logic [8:0] wr_q[$];
  logic [8:0] cv_q[$];
  logic [5:0] pp_q[$];
  out_t out_q[$];
  snn_seq_ctrl_if bus();
  snn_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] outs();
    return {bus.buf_we, bus.buf_sel, bus.buf_waddr, bus.opt_q, bus.cv_valid, bus.cv_img, bus.cv_row,
            bus.cv_col, bus.cv_ch, bus.cv_first, bus.cv_last, bus.pp_valid, bus.pp_op, bus.pp_idx,
            bus.out_valid, bus.out_idx};
  endfunction
  always @(negedge clk) if (rst_n) begin
    if (bus.buf_we) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) check("wr_addr", 32'({bus.buf_sel, bus.buf_waddr}), 32'(wr_q.pop_front()));
    end
    if (bus.cv_valid) begin
      check("pp_in_conv", 32'(bus.pp_valid), 32'd0);
      check("cv_expected", 32'(cv_q.size() != 0), 32'd1);
      if (cv_q.size() != 0)
        check("cv_tuple", 32'({bus.cv_img, bus.cv_row, bus.cv_col, bus.cv_ch, bus.cv_first, bus.cv_last}),
              32'(cv_q.pop_front()));
    end
    if (bus.pp_valid) begin
      check("pp_expected", 32'(pp_q.size() != 0), 32'd1);
      if (pp_q.size() != 0) check("pp_tuple", 32'({bus.pp_op, bus.pp_idx}), 32'(pp_q.pop_front()));
    end
    if (bus.out_valid) begin
      check("overlap", 32'(bus.in_valid), 32'd0);
      check("out_idx", 32'(bus.out_idx), 32'(run));
      if (run == 0) begin
        check("out_expected", 32'(out_q.size() != 0), 32'd1);
        if (out_q.size() != 0) begin
          oe = out_q.pop_front();
          check("out_latency", 32'(cyc), 32'(oe.t));
          check("opt_q", 32'(bus.opt_q), 32'(oe.opt));
        end
      end
      run++;
    end else if (run != 0) begin
      check("out_len", 32'(run), 32'd1);
      run = 0;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int n, input logic [1:0] opt, input bit tog);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.Opt = (k == 0 || !tog) ? opt : 2'($urandom);
      if (k < 127)
        wr_q.push_back(k < 96 ? {2'd0, 7'(k)} : k < 123 ? {2'd1, 7'(k - 96)} : {2'd2, 7'(k - 123)});
      step();
    end
    bus.in_valid = 1'b0;
    bus.Opt = 2'($urandom);
    if (n >= 127) begin
      out_q.push_back('{t: cyc + 153, opt: opt});
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            for (int ch = 0; ch < 3; ch++)
              cv_q.push_back({1'(i), 2'(r), 2'(c), 2'(ch), ch == 0, ch == 2});
      for (int op = 1; op <= 5; op++)
        for (int i = 0; i < (op == 5 ? 1 : 8); i++) pp_q.push_back({3'(op), 3'(i)});
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (out_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("done_timeout", 32'(out_q.size()), 32'd0);
    check("wr_left", 32'(wr_q.size()), 32'd0);
    check("cv_left", 32'(cv_q.size()), 32'd0);
    check("pp_left", 32'(pp_q.size()), 32'd0);
  endtask
  initial begin
    int n;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.Opt = 2'd0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_outs", outs(), 32'd0);
    send(127, 2'b01, 1'b0);
    wait_done();
    repeat (3) step();
    send(50, 2'b11, 1'b0);
    repeat (200) step();
    check("short_left", 32'(wr_q.size() + cv_q.size() + pp_q.size() + out_q.size()), 32'd0);
    send(127, 2'b10, 1'b0);
    wait_done();
    repeat (2) step();
    send(127, 2'b11, 1'b0);
    n = 0;
    while (bus.pp_op != 3'd2 && n < 400) begin
      step();
      n++;
    end
    check("fc_reached", 32'(bus.pp_op), 32'd2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), 32'd0);
    wr_q.delete();
    cv_q.delete();
    pp_q.delete();
    out_q.delete();
    run = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("post_reset", outs(), 32'd0);
    send(127, 2'b01, 1'b0);
    wait_done();
    repeat (2) step();
    send(127, 2'b10, 1'b1);
    wait_done();
    repeat (2) step();
    send(130, 2'b01, 1'b0);
    wait_done();
    for (int p = 0; p < 20; p++) begin
      int g = p == 0 ? 0 : int'($urandom_range(1, 4));
      repeat (g) step();
      send(127, 2'($urandom), 1'b0);
      wait_done();
    end
    repeat (5) step();
    check("final_left", 32'(wr_q.size() + cv_q.size() + pp_q.size() + out_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
